// File: rtl/alu_shifter_unit_pkg.sv
// alu_shifter_unit_pkg
// Shared constants for the execute-stage ALU/shifter block:
//   - ALU opcode encodings (4 bits)
//   - shift kinds used by the immediate-shift form (2 bits)
//   - shifter addressing-mode selects (3 bits)
//   - bit positions of the V/C/Z/N flags in flags_out
package alu_shifter_unit_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        SK_LSL = 2'b00,
        SK_LSR = 2'b01,
        SK_ASR = 2'b10,
        SK_ROR = 2'b11
    } shift_kind_e;

    typedef enum logic [2:0] {
        ST_IMM_SHIFT  = 3'b000,
        ST_ROT_IMM    = 3'b001,
        ST_LS_IMM     = 3'b010,
        ST_LS_SCALED  = 3'b011
    } shift_type_e;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_shifter_unit_shifter_core.sv
// shifter_core
// Combinational operand-2 shifter.
// Ports:
//   i_rm          source register value
//   i_field       instruction bits [11:0]
//   i_type        addressing-mode select
//   i_carry       current C flag (passed through when no shift-out occurs)
//   o_value       shifted/rotated result
//   o_carry       shifter carry-out
module shifter_core
    import alu_shifter_unit_pkg::*;
(
    input  logic [31:0] i_rm,
    input  logic [11:0] i_field,
    input  logic [2:0]  i_type,
    input  logic        i_carry,
    output logic [31:0] o_value,
    output logic        o_carry
);

    logic [4:0]  w_amt;
    logic [1:0]  w_kind;
    logic [32:0] w_lsl;
    logic [32:0] w_lsr;
    logic [32:0] w_asr;
    logic [63:0] w_ror;
    logic [31:0] w_sh_val;
    logic        w_sh_c;
    logic [4:0]  w_rot;
    logic [31:0] w_imm8;
    logic [63:0] w_rot_full;

    assign w_amt  = i_field[11:7];
    assign w_kind = i_field[6:5];

    // Shifting a 33-bit vector keeps the last bit shifted out alongside the
    // result, so the carry falls out of the same shifter.
    assign w_lsl      = {1'b0, i_rm} << w_amt;
    assign w_lsr      = {i_rm, 1'b0} >> w_amt;
    assign w_asr      = 33'($signed({i_rm, 1'b0}) >>> w_amt);
    assign w_ror      = {i_rm, i_rm} >> w_amt;

    assign w_rot      = {i_field[11:8], 1'b0};
    assign w_imm8     = {24'h0, i_field[7:0]};
    assign w_rot_full = {w_imm8, w_imm8} >> w_rot;

    always_comb begin
        w_sh_val = i_rm;
        w_sh_c   = i_carry;
        // Amount 0 is a plain pass-through for every kind (no RRX / #32).
        if (w_amt != 5'd0) begin
            unique case (w_kind)
                SK_LSL: begin
                    w_sh_val = w_lsl[31:0];
                    w_sh_c   = w_lsl[32];
                end
                SK_LSR: begin
                    w_sh_val = w_lsr[32:1];
                    w_sh_c   = w_lsr[0];
                end
                SK_ASR: begin
                    w_sh_val = w_asr[32:1];
                    w_sh_c   = w_asr[0];
                end
                default: begin
                    w_sh_val = w_ror[31:0];
                    w_sh_c   = w_ror[31];
                end
            endcase
        end
    end

    always_comb begin
        o_value = i_rm;
        o_carry = i_carry;
        case (i_type)
            ST_IMM_SHIFT, ST_LS_SCALED: begin
                o_value = w_sh_val;
                o_carry = w_sh_c;
            end
            ST_ROT_IMM: begin
                o_value = w_rot_full[31:0];
                o_carry = (w_rot == 5'd0) ? i_carry : w_rot_full[31];
            end
            ST_LS_IMM: begin
                o_value = {20'h0, i_field};
                o_carry = i_carry;
            end
            default: begin
                o_value = i_rm;
                o_carry = i_carry;
            end
        endcase
    end

endmodule

// File: rtl/alu_shifter_unit.sv
// alu_shifter_unit
// Execute-stage block: 32-bit ALU with NZCV flags plus the operand-2 shifter.
// The two datapaths are independent; each is registered once.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   a_in, b_in        ALU operands (Rn, shifter operand)
//   carry_in          current C flag
//   opcode            ALU operation
//   alu_out           registered ALU result
//   flags_out         registered flags {V,C,Z,N}
//   rm_in             shifter source register
//   shift_field       instruction bits [11:0]
//   shift_type        shifter addressing mode
//   shift_out         registered shifter result
//   shift_carry_out   registered shifter carry
module alu_shifter_unit
    import alu_shifter_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        carry_in,
    input  logic [3:0]  opcode,
    output logic [31:0] alu_out,
    output logic [3:0]  flags_out,
    input  logic [31:0] rm_in,
    input  logic [11:0] shift_field,
    input  logic [2:0]  shift_type,
    output logic [31:0] shift_out,
    output logic        shift_carry_out
);

    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic        w_arith;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_flags;
    logic [31:0] w_sh_val;
    logic        w_sh_c;

    logic [31:0] r_alu;
    logic [3:0]  r_flags;
    logic [31:0] r_sh;
    logic        r_sh_c;

    // Adder operand selection: subtracts become x + ~y + carry.
    always_comb begin
        w_x     = a_in;
        w_y     = b_in;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (alu_op_e'(opcode))
            OP_SUB, OP_CMP: begin w_x = a_in; w_y = ~b_in; w_cin = 1'b1;     end
            OP_RSB:         begin w_x = b_in; w_y = ~a_in; w_cin = 1'b1;     end
            OP_ADD, OP_CMN: begin w_x = a_in; w_y = b_in;  w_cin = 1'b0;     end
            OP_ADC:         begin w_x = a_in; w_y = b_in;  w_cin = carry_in; end
            OP_SBC:         begin w_x = a_in; w_y = ~b_in; w_cin = carry_in; end
            OP_RSC:         begin w_x = b_in; w_y = ~a_in; w_cin = carry_in; end
            default:        w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'h0, w_cin};

    always_comb begin
        w_res = w_sum[31:0];
        case (alu_op_e'(opcode))
            OP_AND, OP_TST: w_res = a_in & b_in;
            OP_EOR, OP_TEQ: w_res = a_in ^ b_in;
            OP_ORR:         w_res = a_in | b_in;
            OP_MOV:         w_res = b_in;
            OP_BIC:         w_res = a_in & ~b_in;
            OP_MVN:         w_res = ~b_in;
            default:        w_res = w_sum[31:0];
        endcase
    end

    // Overflow is judged on the effective addend (already inverted for subtracts).
    assign w_c = w_arith ? w_sum[32] : carry_in;
    assign w_v = w_arith & (w_x[31] == w_y[31]) & (w_sum[31] != w_x[31]);

    always_comb begin
        w_flags         = 4'h0;
        w_flags[FLAG_N] = w_res[31];
        w_flags[FLAG_Z] = (w_res == 32'h0);
        w_flags[FLAG_C] = w_c;
        w_flags[FLAG_V] = w_v;
    end

    shifter_core u_shifter_core (
        .i_rm    (rm_in),
        .i_field (shift_field),
        .i_type  (shift_type),
        .i_carry (carry_in),
        .o_value (w_sh_val),
        .o_carry (w_sh_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu   <= 32'h0;
            r_flags <= 4'h0;
            r_sh    <= 32'h0;
            r_sh_c  <= 1'b0;
        end else begin
            r_alu   <= w_res;
            r_flags <= w_flags;
            r_sh    <= w_sh_val;
            r_sh_c  <= w_sh_c;
        end
    end

    assign alu_out         = r_alu;
    assign flags_out       = r_flags;
    assign shift_out       = r_sh;
    assign shift_carry_out = r_sh_c;

endmodule

// File: tb/tb_alu_shifter_unit.sv
module tb_alu_shifter_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        carry_in;
    logic [3:0]  opcode;
    logic [31:0] alu_out;
    logic [3:0]  flags_out;
    logic [31:0] rm_in;
    logic [11:0] shift_field;
    logic [2:0]  shift_type;
    logic [31:0] shift_out;
    logic        shift_carry_out;

    int total = 0;
    int bad   = 0;

    alu_shifter_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_in            (a_in),
        .b_in            (b_in),
        .carry_in        (carry_in),
        .opcode          (opcode),
        .alu_out         (alu_out),
        .flags_out       (flags_out),
        .rm_in           (rm_in),
        .shift_field     (shift_field),
        .shift_type      (shift_type),
        .shift_out       (shift_out),
        .shift_carry_out (shift_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input string tag,
                       input logic [31:0] exp_r, input logic [3:0] exp_f);
        @(negedge clk);
        opcode = op; a_in = a; b_in = b; carry_in = cin;
        step();
        chk32({tag, "_res"}, alu_out, exp_r);
        chk4({tag, "_vczn"}, flags_out, exp_f);
    endtask

    task automatic shf(input logic [2:0] st, input logic [31:0] rm, input logic [11:0] fld,
                       input logic cin, input string tag,
                       input logic [31:0] exp_v, input logic exp_c);
        @(negedge clk);
        shift_type = st; rm_in = rm; shift_field = fld; carry_in = cin;
        step();
        chk32({tag, "_val"}, shift_out, exp_v);
        chk1({tag, "_c"}, shift_carry_out, exp_c);
    endtask

    initial begin
        rst_n = 1'b0;
        a_in = 32'h1234_5678; b_in = 32'h0F0F_0F0F; carry_in = 1'b1; opcode = 4'h4;
        rm_in = 32'hFFFF_FFFF; shift_field = 12'hFFF; shift_type = 3'b000;
        step();
        chk32("reset_alu", alu_out, 32'h0);
        chk4("reset_flags", flags_out, 4'h0);
        chk32("reset_sh", shift_out, 32'h0);
        chk1("reset_shc", shift_carry_out, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // flags are {V,C,Z,N}
        alu(4'h4, 32'h8000_6172, 32'h8031_0333, 1'b0, "add_ovf", 32'h0031_64A5, 4'b1100);
        alu(4'h4, 32'd6,         32'd10,        1'b1, "add_small", 32'h10,      4'b0000);
        alu(4'h2, 32'd5,         32'd5,         1'b0, "sub_zero",  32'h0,       4'b0110);
        alu(4'h6, 32'd13,        32'd5,         1'b0, "sbc",       32'd7,       4'b0100);
        alu(4'h3, 32'd5,         32'd13,        1'b0, "rsb",       32'd8,       4'b0100);
        alu(4'h2, 32'd3,         32'd5,         1'b1, "sub_borrow", 32'hFFFF_FFFE, 4'b0001);
        alu(4'h5, 32'hFFFF_FFFF, 32'd0,         1'b1, "adc_wrap",  32'h0,       4'b0110);
        alu(4'h7, 32'd5,         32'd13,        1'b0, "rsc",       32'd7,       4'b0100);
        alu(4'hA, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "cmp_ovf",   32'h8000_0000, 4'b1001);
        alu(4'hE, 32'hD,         32'h5,         1'b1, "bic",       32'h8,       4'b0100);
        alu(4'hF, 32'h0,         32'h5,         1'b1, "mvn",       32'hFFFF_FFFA, 4'b0101);
        alu(4'h9, 32'hD,         32'hD,         1'b1, "teq",       32'h0,       4'b0110);
        alu(4'hC, 32'hF0,        32'h0F,        1'b0, "orr",       32'hFF,      4'b0000);
        alu(4'h0, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, "and",       32'hF000_F000, 4'b0001);
        alu(4'hB, 32'hFFFF_FFFF, 32'd1,         1'b0, "cmn",       32'h0,       4'b0110);

        shf(3'b000, 32'hEB00_0007, 12'h387, 1'b0, "lsl7",  32'h8000_0380, 1'b1);
        shf(3'b000, 32'hEB00_0007, 12'h3A7, 1'b1, "lsr7",  32'h01D6_0000, 1'b0);
        shf(3'b000, 32'hEB00_0007, 12'h3C7, 1'b1, "asr7",  32'hFFD6_0000, 1'b0);
        shf(3'b000, 32'hEB00_0007, 12'h0E7, 1'b0, "ror1",  32'hF580_0003, 1'b1);
        shf(3'b000, 32'hEB00_0007, 12'h047, 1'b1, "amt0_c1", 32'hEB00_0007, 1'b1);
        shf(3'b000, 32'hEB00_0007, 12'h067, 1'b0, "amt0_c0", 32'hEB00_0007, 1'b0);
        shf(3'b011, 32'hEB00_0007, 12'h387, 1'b0, "scaled_lsl7", 32'h8000_0380, 1'b1);
        shf(3'b001, 32'h0,         12'h387, 1'b1, "rotimm", 32'h1C00_0002, 1'b0);
        shf(3'b001, 32'h0,         12'h0AB, 1'b1, "rotimm0", 32'h0000_00AB, 1'b1);
        shf(3'b010, 32'hDEAD_BEEF, 12'h5D5, 1'b1, "ls_imm", 32'h0000_05D5, 1'b1);
        shf(3'b110, 32'hDEAD_BEEF, 12'h387, 1'b0, "type6", 32'hDEAD_BEEF, 1'b0);

        // Mid-stream reset with nonzero inputs, then release.
        @(negedge clk);
        opcode = 4'h4; a_in = 32'd6; b_in = 32'd10; carry_in = 1'b1;
        shift_type = 3'b000; rm_in = 32'hEB00_0007; shift_field = 12'h387;
        rst_n = 1'b0;
        step();
        chk32("rst_mid_alu", alu_out, 32'h0);
        chk4("rst_mid_flags", flags_out, 4'h0);
        chk32("rst_mid_sh", shift_out, 32'h0);
        chk1("rst_mid_shc", shift_carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk32("rel_alu", alu_out, 32'h10);
        chk4("rel_flags", flags_out, 4'b0000);
        chk32("rel_sh", shift_out, 32'h8000_0380);
        chk1("rel_shc", shift_carry_out, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
